radix2_feeder: RTL and testbench

RADIX2_FEEDER -- requirements
Module: radix2_feeder

---
 rtl/radix2_feeder_if.sv | 41 ++++
 rtl/radix2_feeder.sv | 129 ++++++++++++
 tb/tb_radix2_feeder.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/radix2_feeder_if.sv
// Sample-in / butterfly-pair-out bundle for radix2_feeder.
// The slave modport is the feeder itself; the master modport is the
// upstream sample source together with the downstream butterfly.
interface radix2_feeder_if #(
    parameter int WIDTH     = 24,
    parameter int LOG_DEPTH = 3
);
    // serial natural-order input stream
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;

    // butterfly operand pair towards the datapath
    logic                 out_valid;
    logic [WIDTH-1:0]     rdup_out;
    logic [WIDTH-1:0]     rdlo_out;
    logic [LOG_DEPTH-1:0] coef_idx;
    logic                 frame_start;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  rdup_out,
        input  rdlo_out,
        input  coef_idx,
        input  frame_start
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output rdup_out,
        output rdlo_out,
        output coef_idx,
        output frame_start
    );
endinterface

// File: rtl/radix2_feeder.sv
// Radix-2 butterfly operand feeder.
// A block of 2*DEPTH natural-order samples arrives serially. The first
// DEPTH samples (FILL) are parked in a buffer; each of the next DEPTH
// samples (PAIR) is emitted as the lower operand x[k+DEPTH] alongside the
// buffered upper operand x[k] and twiddle index k, one cycle after accept.
// Samples pass bit-exact; the packed {re, im} layout is never split.
module radix2_feeder #(
    parameter int WIDTH     = 24,
    parameter int LOG_DEPTH = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               clr,
    radix2_feeder_if.slave     bus
);
    localparam int unsigned DEPTH = 2 ** LOG_DEPTH;
    localparam logic [LOG_DEPTH-1:0] K_LAST = '1;
    localparam logic [LOG_DEPTH-1:0] K_ONE  = LOG_DEPTH'(1);

    // {phase, k} together form the block position counter; phase is its MSB
    typedef enum logic {
        FILL = 1'b0,
        PAIR = 1'b1
    } phase_t;

    phase_t               phase;
    phase_t               phase_nxt;
    logic [LOG_DEPTH-1:0] k;
    logic [LOG_DEPTH-1:0] k_nxt;

    // parked upper operands x[0..DEPTH-1]; no reset needed, always written before read
    logic [WIDTH-1:0]     buffer [DEPTH];
    logic                 buf_we;

    // output registers and their next values
    logic                 valid_q;
    logic                 valid_nxt;
    logic                 fs_q;
    logic                 fs_nxt;
    logic [WIDTH-1:0]     up_q;
    logic [WIDTH-1:0]     up_nxt;
    logic [WIDTH-1:0]     lo_q;
    logic [WIDTH-1:0]     lo_nxt;
    logic [LOG_DEPTH-1:0] coef_q;
    logic [LOG_DEPTH-1:0] coef_nxt;

    // a stalled butterfly cannot take a pair, so no sample is taken either
    assign bus.in_ready = !stall;

    assign bus.out_valid   = valid_q;
    assign bus.frame_start = fs_q;
    assign bus.rdup_out    = up_q;
    assign bus.rdlo_out    = lo_q;
    assign bus.coef_idx    = coef_q;

    // position counter and output registers, asynchronously cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase   <= FILL;
            k       <= '0;
            valid_q <= 1'b0;
            fs_q    <= 1'b0;
            up_q    <= '0;
            lo_q    <= '0;
            coef_q  <= '0;
        end else begin
            phase   <= phase_nxt;
            k       <= k_nxt;
            valid_q <= valid_nxt;
            fs_q    <= fs_nxt;
            up_q    <= up_nxt;
            lo_q    <= lo_nxt;
            coef_q  <= coef_nxt;
        end
    end

    // next position, buffer write enable and next output pair
    always_comb begin
        phase_nxt = phase;
        k_nxt     = k;
        valid_nxt = valid_q;
        fs_nxt    = fs_q;
        up_nxt    = up_q;
        lo_nxt    = lo_q;
        coef_nxt  = coef_q;
        buf_we    = 1'b0;

        if (clr) begin
            // restart wins over stall and swallows any sample offered now
            phase_nxt = FILL;
            k_nxt     = '0;
            valid_nxt = 1'b0;
            fs_nxt    = 1'b0;
        end else if (!stall) begin
            valid_nxt = 1'b0;
            fs_nxt    = 1'b0;
            if (bus.in_valid) begin
                k_nxt = k + K_ONE;
                if (k == K_LAST) begin
                    case (phase)
                        FILL:    phase_nxt = PAIR;
                        PAIR:    phase_nxt = FILL;
                        default: phase_nxt = FILL;
                    endcase
                end
                case (phase)
                    FILL: buf_we = 1'b1;
                    PAIR: begin
                        // buffer[k] is consumed here, before next block's FILL rewrites it
                        up_nxt    = buffer[k];
                        lo_nxt    = bus.in_data;
                        coef_nxt  = k;
                        valid_nxt = 1'b1;
                        fs_nxt    = (k == '0);
                    end
                    default: buf_we = 1'b0;
                endcase
            end
        end
    end

    // park FILL samples at their k slot
    always_ff @(posedge clk) begin
        if (buf_we) begin
            buffer[k] <= bus.in_data;
        end
    end
endmodule

// File: tb/tb_radix2_feeder.sv
// Self-checking bench for radix2_feeder with DEPTH = 4.
// A stream model pushes each expected pair when its lower sample is
// accepted; a negedge monitor pops and compares when the DUT shows it.
module tb_radix2_feeder;
    localparam int W     = 24;
    localparam int LD    = 2;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [W-1:0]  up;
        logic [W-1:0]  lo;
        logic [LD-1:0] k;
    } pair_t;

    logic clk;
    logic rst;
    logic stall;
    logic clr;

    radix2_feeder_if #(.WIDTH(W), .LOG_DEPTH(LD)) bus ();

    radix2_feeder #(.WIDTH(W), .LOG_DEPTH(LD)) dut (
        .clk   (clk),
        .rst   (rst),
        .stall (stall),
        .clr   (clr),
        .bus   (bus)
    );

    int    n_checks = 0;
    int    n_errors = 0;

    pair_t exp_q [$];
    pair_t got_log [$];

    logic [W-1:0] m_buf [DEPTH];
    int           m_cnt = 0;
    logic         pend = 1'b0;
    logic         edge_hold = 1'b0;

    logic          h_valid;
    logic          h_fs;
    logic [W-1:0]  h_up;
    logic [W-1:0]  h_lo;
    logic [LD-1:0] h_k;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // stream model: what the block must emit, derived from accepted samples
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt = 0;
            exp_q.delete();
            pend = 1'b0;
            edge_hold = 1'b0;
        end else begin
            edge_hold = stall && !clr;
            pend = 1'b0;
            if (clr) begin
                m_cnt = 0;
            end else if (!stall && bus.in_valid) begin
                if (m_cnt < DEPTH) begin
                    m_buf[m_cnt] = bus.in_data;
                end else begin
                    exp_q.push_back('{up: m_buf[m_cnt-DEPTH], lo: bus.in_data, k: LD'(m_cnt-DEPTH)});
                    pend = 1'b1;
                end
                m_cnt = (m_cnt + 1) % (2 * DEPTH);
            end
        end
    end

    // monitor: away from the active edge
    always @(negedge clk) begin
        pair_t e;
        if (!rst) begin
            check("in_ready", {31'd0, bus.in_ready}, {31'd0, !stall});
            if (edge_hold) begin
                check("hold_valid", {31'd0, bus.out_valid}, {31'd0, h_valid});
                check("hold_fs", {31'd0, bus.frame_start}, {31'd0, h_fs});
                check("hold_up", 32'(bus.rdup_out), 32'(h_up));
                check("hold_lo", 32'(bus.rdlo_out), 32'(h_lo));
                check("hold_k", 32'(bus.coef_idx), 32'(h_k));
            end else begin
                check("out_valid", {31'd0, bus.out_valid}, {31'd0, pend});
                if (pend && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("rdup", 32'(bus.rdup_out), 32'(e.up));
                    check("rdlo", 32'(bus.rdlo_out), 32'(e.lo));
                    check("coef", 32'(bus.coef_idx), 32'(e.k));
                    check("frame_start", {31'd0, bus.frame_start}, {31'd0, e.k == '0});
                end else begin
                    check("frame_idle", {31'd0, bus.frame_start}, 32'd0);
                end
                if (bus.out_valid)
                    got_log.push_back('{up: bus.rdup_out, lo: bus.rdlo_out, k: bus.coef_idx});
            end
        end
        h_valid = bus.out_valid;
        h_fs    = bus.frame_start;
        h_up    = bus.rdup_out;
        h_lo    = bus.rdlo_out;
        h_k     = bus.coef_idx;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v);
        bus.in_valid = 1'b1;
        bus.in_data  = W'(v);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic send_rand(input int v);
        logic acc;
        int   tries = 0;
        do begin
            acc = (tries > 20) ? 1'b1 : 1'(($urandom_range(0, 1)));
            bus.in_valid = acc;
            bus.in_data  = acc ? W'(v) : W'($urandom);
            step();
            tries++;
        end while (!acc);
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    // pairs logged from index idx0 must be (first+i, first+i+DEPTH, k=i)
    task automatic check_block(input string tag, input int idx0, input int first);
        check({tag, "_count"}, 32'(got_log.size() >= idx0 + DEPTH), 32'd1);
        if (got_log.size() >= idx0 + DEPTH) begin
            for (int i = 0; i < DEPTH; i++) begin
                check({tag, "_up"}, 32'(got_log[idx0+i].up), 32'(first + i));
                check({tag, "_lo"}, 32'(got_log[idx0+i].lo), 32'(first + i + DEPTH));
                check({tag, "_k"},  32'(got_log[idx0+i].k),  32'(i));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        clr = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        #1;
        check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_fs", {31'd0, bus.frame_start}, 32'd0);
        check("rst_up", 32'(bus.rdup_out), 32'd0);
        check("rst_lo", 32'(bus.rdlo_out), 32'd0);
        check("rst_k", 32'(bus.coef_idx), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // back-to-back single block
        got_log.delete();
        for (int v = 1; v <= 8; v++) send(v);
        idle(2);
        check_block("basic", 0, 1);

        // stall for 3 cycles after the second pair
        got_log.delete();
        for (int v = 1; v <= 6; v++) send(v);
        stall = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = W'(7);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_ready", {31'd0, bus.in_ready}, 32'd0);
            check("stall_up", 32'(bus.rdup_out), 32'd2);
            check("stall_lo", 32'(bus.rdlo_out), 32'd6);
            check("stall_k", 32'(bus.coef_idx), 32'd1);
        end
        stall = 1'b0;
        send(7);
        send(8);
        idle(2);
        check_block("stall", 0, 1);

        // two blocks back-to-back
        got_log.delete();
        for (int v = 1; v <= 16; v++) send(v);
        idle(2);
        check_block("blk1", 0, 1);
        check_block("blk2", DEPTH, 9);

        // clr after sample 6, sample offered with clr is dropped
        got_log.delete();
        for (int v = 1; v <= 6; v++) send(v);
        clr = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = W'(99);
        step();
        clr = 1'b0;
        bus.in_valid = 1'b0;
        check("clr_valid", {31'd0, bus.out_valid}, 32'd0);
        got_log.delete();
        for (int v = 1; v <= 8; v++) send(v);
        idle(2);
        check_block("clr", 0, 1);

        // asynchronous reset mid-PAIR
        for (int v = 1; v <= 6; v++) send(v);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", {31'd0, bus.out_valid}, 32'd0);
        check("arst_fs", {31'd0, bus.frame_start}, 32'd0);
        check("arst_up", 32'(bus.rdup_out), 32'd0);
        check("arst_lo", 32'(bus.rdlo_out), 32'd0);
        check("arst_k", 32'(bus.coef_idx), 32'd0);
        step();
        rst = 1'b0;
        step();
        got_log.delete();
        for (int v = 1; v <= 8; v++) send(v);
        idle(2);
        check_block("arst", 0, 1);

        // random 50% in_valid duty
        got_log.delete();
        for (int v = 1; v <= 8; v++) send_rand(v);
        idle(2);
        check_block("rand", 0, 1);
        check("rand_pairs", 32'(got_log.size()), 32'(DEPTH));

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
